// File: rtl/sync_timing_gen.sv
// Sync front end: synchronises csync/vsync/field, rejects half-line pulses and runs a
// line/column timing generator with lock FSM. Define SYNC_FLYWHEEL_EN for synthetic lines.
module sync_timing_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic       csync_in,
  input  logic       vsync_in,
  input  logic       field_in,
  output logic [9:0] line_count,
  output logic [9:0] column_count,
  output logic       line_start,
  output logic       frame_start,
  output logic       field_out,
  output logic       locked,
  output logic       active
);

  localparam logic [9:0] H_REJECT       = 10'd192;
  localparam logic [9:0] H_MIN          = 10'd248;
  localparam logic [9:0] H_MAX          = 10'd260;
  localparam logic [3:0] LOCK_LINES     = 4'd8;
`ifdef SYNC_FLYWHEEL_EN
  localparam logic [2:0] MISS_LIMIT     = 3'd4;
`endif
  localparam logic [9:0] LINE_LIMIT     = 10'd300;
  localparam logic [9:0] LINE_ACT_START = 10'd20;
  localparam logic [9:0] LINE_ACT_END   = 10'd259;
  localparam logic [9:0] COL_ACT_START  = 10'd40;
  localparam logic [9:0] COL_ACT_END    = 10'd240;

  typedef enum logic [1:0] {StSearch, StVerify, StLocked} state_e;

  logic cs_s1_q, cs_s2_q, cs_d3_q, cs_fall_q;
  logic vs_s1_q, vs_s2_q, vs_d3_q, vs_fall_q;
  logic field_s1_q, field_out_q;

  logic [9:0] line_q, line_d, col_q, col_d;
  logic       line_start_q, frame_start_q, locked_q, active_q;
  state_e     state_q, state_d;
  logic [3:0] good_q, good_d;
`ifdef SYNC_FLYWHEEL_EN
  logic [2:0] miss_q, miss_d;
  logic       syn_line;
`endif
  logic       hs_acc, line_strobe, period_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_d3_q     <= 1'b1;
      cs_fall_q   <= 1'b0;
      vs_s1_q     <= 1'b1;
      vs_s2_q     <= 1'b1;
      vs_d3_q     <= 1'b1;
      vs_fall_q   <= 1'b0;
      field_s1_q  <= 1'b1;
      field_out_q <= 1'b0;
    end else begin
      cs_s1_q     <= csync_in;
      cs_s2_q     <= cs_s1_q;
      cs_d3_q     <= cs_s2_q;
      cs_fall_q   <= cs_d3_q & ~cs_s2_q;
      vs_s1_q     <= vsync_in;
      vs_s2_q     <= vs_s1_q;
      vs_d3_q     <= vs_s2_q;
      vs_fall_q   <= vs_d3_q & ~vs_s2_q;
      field_s1_q  <= field_in;
      field_out_q <= field_s1_q;
    end
  end

  always_comb begin
    // Edges early in the line are equalising/serration pulses and never count as hsync.
    hs_acc    = cs_fall_q && (col_q >= H_REJECT);
    period_ok = (col_q >= H_MIN) && (col_q <= H_MAX);
`ifdef SYNC_FLYWHEEL_EN
    syn_line    = (col_q == H_MAX) && !hs_acc;
    line_strobe = hs_acc || syn_line;
`else
    line_strobe = hs_acc;
`endif

    if (line_strobe) begin
      col_d = 10'd0;
    end else if (col_q == 10'd1023) begin
      col_d = col_q;
    end else begin
      col_d = col_q + 10'd1;
    end

    if (vs_fall_q) begin
      line_d = 10'd0;
    end else if (line_strobe && (line_q != 10'd1023)) begin
      line_d = line_q + 10'd1;
    end else begin
      line_d = line_q;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
`ifdef SYNC_FLYWHEEL_EN
    miss_d  = miss_q;
`endif
    unique case (state_q)
      StSearch: begin
        if (vs_fall_q) begin
          state_d = StVerify;
          good_d  = 4'd0;
        end
      end
      StVerify: begin
        if (hs_acc) begin
          if (period_ok) begin
            good_d = good_q + 4'd1;
            if (good_d == LOCK_LINES) begin
              state_d = StLocked;
`ifdef SYNC_FLYWHEEL_EN
              miss_d  = 3'd0;
`endif
            end
          end else begin
            state_d = StSearch;
          end
`ifdef SYNC_FLYWHEEL_EN
        end else if (syn_line) begin
`else
        end else if (col_q == H_MAX) begin
`endif
          state_d = StSearch;
        end
      end
      StLocked: begin
`ifdef SYNC_FLYWHEEL_EN
        if (hs_acc) begin
          miss_d = 3'd0;
        end else if (syn_line) begin
          miss_d = miss_q + 3'd1;
          if (miss_d == MISS_LIMIT) state_d = StSearch;
        end
`else
        if (!hs_acc && (col_q == H_MAX)) state_d = StSearch;
`endif
        if (line_q >= LINE_LIMIT) state_d = StSearch;
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StSearch;
      good_q        <= 4'd0;
`ifdef SYNC_FLYWHEEL_EN
      miss_q        <= 3'd0;
`endif
      line_q        <= 10'd0;
      col_q         <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
`ifdef SYNC_FLYWHEEL_EN
      miss_q        <= miss_d;
`endif
      line_q        <= line_d;
      col_q         <= col_d;
      line_start_q  <= line_strobe;
      frame_start_q <= vs_fall_q;
      locked_q      <= (state_d == StLocked);
      // Window compare on next-state counts so active lines up with the counts it is shown with.
      active_q      <= (state_d == StLocked) &&
                       (line_d >= LINE_ACT_START) && (line_d <= LINE_ACT_END) &&
                       (col_d >= COL_ACT_START) && (col_d <= COL_ACT_END);
    end
  end

  assign line_count   = line_q;
  assign column_count = col_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign field_out    = field_out_q;
  assign locked       = locked_q;
  assign active       = active_q;

endmodule

// File: tb/tb_sync_timing_gen.sv
// Directed bench for sync_timing_gen: line/frame timing, lock, half-line rejection,
// missing-sync handling (both SYNC_FLYWHEEL_EN builds) and asynchronous reset.
module tb_sync_timing_gen;

  logic       clk = 1'b0;
  logic       reset, csync_in, vsync_in, field_in;
  logic [9:0] line_count, column_count;
  logic       line_start, frame_start, field_out, locked, active;

  int checks = 0;
  int errors = 0;

  int rec_col[0:1023];
  int rec_lc[0:1023];
  int rec_ls[0:1023];
  int rec_fs[0:1023];
  int rec_lk[0:1023];
  int rec_act[0:1023];

  sync_timing_gen dut (
    .clk          (clk),
    .reset        (reset),
    .csync_in     (csync_in),
    .vsync_in     (vsync_in),
    .field_in     (field_in),
    .line_count   (line_count),
    .column_count (column_count),
    .line_start   (line_start),
    .frame_start  (frame_start),
    .field_out    (field_out),
    .locked       (locked),
    .active       (active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One line of per+1 clocks; sync pulses are 8 clocks low. rec_*[c] holds the outputs
  // 1 time unit after the (c+1)-th clock edge of the line.
  task automatic drive_line(input int per, input bit vs, input bit pulse, input bit half);
    csync_in = !pulse;
    vsync_in = !vs;
    for (int c = 0; c <= per; c++) begin
      @(posedge clk);
      #1;
      rec_col[c] = int'(column_count);
      rec_lc[c]  = int'(line_count);
      rec_ls[c]  = int'(line_start);
      rec_fs[c]  = int'(frame_start);
      rec_lk[c]  = int'(locked);
      rec_act[c] = int'(active);
      if (c == 7) begin
        csync_in = 1'b1;
        vsync_in = 1'b1;
      end
      if (half && c == 120) csync_in = 1'b0;
      if (half && c == 128) csync_in = 1'b1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    csync_in = 1'b1;
    vsync_in = 1'b1;
    field_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_line_count", int'(line_count), 0);
    check_eq("rst_column_count", int'(column_count), 0);
    check_eq("rst_line_start", int'(line_start), 0);
    check_eq("rst_frame_start", int'(frame_start), 0);
    check_eq("rst_locked", int'(locked), 0);
    check_eq("rst_active", int'(active), 0);
    check_eq("rst_field_out", int'(field_out), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_col", int'(column_count), 1);

    field_in = 1'b1;
    @(posedge clk);
    #1;
    check_eq("field_delay1", int'(field_out), 0);
    @(posedge clk);
    #1;
    check_eq("field_delay2", int'(field_out), 1);
    repeat (226) @(posedge clk);
    #1;

    // 22 lines of period 254, vsync with line 0, half-line pulse in line 12.
    for (int i = 0; i < 22; i++) begin
      drive_line(254, i == 0, 1'b1, i == 12);
      check_eq($sformatf("ls_%0d", i), rec_ls[3], 1);
      check_eq($sformatf("ls_off_%0d", i), rec_ls[4], 0);
      check_eq($sformatf("col0_%0d", i), rec_col[3], 0);
      check_eq($sformatf("lc_%0d", i), rec_lc[3], i);
      check_eq($sformatf("fs_%0d", i), rec_fs[3], int'(i == 0));
      check_eq($sformatf("lk_pre_%0d", i), rec_lk[2], int'(i >= 9));
      check_eq($sformatf("lk_%0d", i), rec_lk[200], int'(i >= 8));
      check_eq($sformatf("lc_end_%0d", i), rec_lc[200], i);
      check_eq($sformatf("col_end_%0d", i), rec_col[200], 197);
      check_eq($sformatf("act_col40_%0d", i), rec_act[43], int'(i >= 20));
      check_eq($sformatf("act_col39_%0d", i), rec_act[42], 0);
      check_eq($sformatf("act_col57_%0d", i), rec_act[60], int'(i >= 20));
      check_eq($sformatf("act_col247_%0d", i), rec_act[250], 0);
    end

`ifdef SYNC_FLYWHEEL_EN
    drive_line(1000, 1'b0, 1'b0, 1'b0);
    check_eq("fly_col260", rec_col[8], 260);
    check_eq("fly_ls1", rec_ls[9], 1);
    check_eq("fly_col0", rec_col[9], 0);
    check_eq("fly_ls2", rec_ls[270], 1);
    check_eq("fly_ls3", rec_ls[531], 1);
    check_eq("fly_ls4", rec_ls[792], 1);
    check_eq("fly_lc1", rec_lc[10], 22);
    check_eq("fly_lc4", rec_lc[800], 25);
    check_eq("fly_lk3", rec_lk[791], 1);
    check_eq("fly_lk4", rec_lk[800], 0);
`else
    drive_line(254, 1'b0, 1'b0, 1'b0);
    check_eq("nofly_col260", rec_col[8], 260);
    check_eq("nofly_lk_at260", rec_lk[8], 1);
    check_eq("nofly_lk_after", rec_lk[9], 0);
    check_eq("nofly_no_syn", rec_ls[9], 0);
    check_eq("nofly_col261", rec_col[9], 261);
    drive_line(600, 1'b0, 1'b0, 1'b0);
    check_eq("sat_col1022", rec_col[515], 1022);
    check_eq("sat_col1023", rec_col[516], 1023);
    check_eq("sat_hold", rec_col[600], 1023);
    check_eq("sat_lc", rec_lc[600], 21);
`endif

    // Bad period while verifying drops back to search; no further vsync, so no lock.
    drive_line(254, 1'b1, 1'b1, 1'b0);
    check_eq("ver_fs", rec_fs[3], 1);
    check_eq("ver_lc0", rec_lc[3], 0);
    drive_line(254, 1'b0, 1'b1, 1'b0);
    drive_line(230, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive_line(254, 1'b0, 1'b1, 1'b0);
      check_eq($sformatf("ver_lc_%0d", k), rec_lc[3], k + 3);
      check_eq($sformatf("ver_lk_%0d", k), rec_lk[200], 0);
    end

    // Relock, then reset mid-line.
    drive_line(254, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) drive_line(254, 1'b0, 1'b1, 1'b0);
    check_eq("relock_lc", rec_lc[3], 10);
    check_eq("relock_lk", rec_lk[200], 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_lk", int'(locked), 1);
    check_eq("pre_rst_col", int'(column_count), 254);
    #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_line_count", int'(line_count), 0);
    check_eq("mid_rst_column_count", int'(column_count), 0);
    check_eq("mid_rst_line_start", int'(line_start), 0);
    check_eq("mid_rst_frame_start", int'(frame_start), 0);
    check_eq("mid_rst_locked", int'(locked), 0);
    check_eq("mid_rst_active", int'(active), 0);
    check_eq("mid_rst_field_out", int'(field_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_line(254, 1'b0, 1'b1, 1'b0);
      check_eq($sformatf("post_rst_lc_%0d", k), rec_lc[3], k);
      check_eq($sformatf("post_rst_lk_%0d", k), rec_lk[200], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_timing_gen.md
# sync_timing_gen

Sync front end for the overlay CPLD. Synchronises the sync separator's active-low csync/vsync/field outputs into the 4 MHz domain and rejects equalising half-line pulses. Runs a flywheel line/column timing generator with a lock state machine, producing clean line_count/column_count, strobes and an active-window flag. The crosshair comparators and gate logic downstream consume these outputs in place of raw-sync-clocked counters.

## Interface
- H_REJECT, 10'd192: minimum column_count at which a csync falling edge is accepted as hsync (shorter = equalising/serration pulse, ignored)
- H_MIN, 10'd248: minimum good line period (clk cycles)
- H_MAX, 10'd260: maximum good line period; flywheel point
- LOCK_LINES, 4'd8: consecutive good lines needed to lock
- MISS_LIMIT, 3'd4: consecutive synthetic lines before lock loss
- LINE_LIMIT, 10'd300: line_count value that forces lock loss without vsync
- LINE_ACT_START / LINE_ACT_END, 10'd20 / 10'd259: active line window, inclusive
- COL_ACT_START / COL_ACT_END, 10'd40 / 10'd240: active column window, inclusive

- clk  in  1  4 MHz system clock (clk4mhz at top level)
- reset  in  1  asynchronous, active-high reset
- csync_in  in  1  composite sync, active low, asynchronous
- vsync_in  in  1  vertical sync, active low, asynchronous
- field_in  in  1  odd/even field flag, asynchronous
- line_count  out  10  current line within field
- column_count  out  10  clk cycles since line start
- line_start  out  1  one-cycle strobe, real or synthetic line start
- frame_start  out  1  one-cycle strobe on accepted vsync
- field_out  out  1  synchronised field_in
- locked  out  1  FSM in LOCKED
- active  out  1  locked and both counts inside their active windows

## Operation
- Inputs pass through 2-flop synchronisers (reset to 1), then a third edge-detect flop. A falling edge is "cs_fall"/"vs_fall".
- hsync accept: cs_fall with column_count >= H_REJECT. Period = column_count at that cycle. Edges below H_REJECT are ignored entirely.
- Column counter: next cycle after accepted hsync or synthetic line → 0; otherwise +1, saturating at 1023.
- Synthetic line: column_count == H_MAX with no accepted hsync that cycle (flywheel). A real edge in the same cycle wins.
- Line counter:
  - vs_fall → 0 and frame_start.
  - Else line_start → +1, saturating at 1023.
  - vs_fall wins over a simultaneous line_start.
- FSM states SEARCH, VERIFY, LOCKED:
  - SEARCH: vs_fall → VERIFY, good count cleared.
  - VERIFY: accepted hsync with period in [H_MIN,H_MAX] → good+1; reaching LOCK_LINES → LOCKED. Period outside → SEARCH. Synthetic line → SEARCH.
  - LOCKED: synthetic line → miss+1; accepted hsync → miss cleared. miss reaching MISS_LIMIT → SEARCH. line_count reaching LINE_LIMIT → SEARCH. Out-of-range periods are tolerated in LOCKED.
- Counters and strobes run in every state; only locked/active depend on state.
- field_out = synchronised field_in, 2-cycle delay.

## Timing
- Reset values:
  - line_count = column_count = 0
  - line_start, frame_start, locked, active, field_out = 0
  - FSM = SEARCH; good/miss counts = 0; synchronisers = 1
- Reset is asynchronous: mid-line assertion clears everything immediately, and the FSM re-searches after release.
- Latency: csync_in low setup before clk edge N → cs_fall at edge N+2 → line_start high and column_count == 0 in the cycle after edge N+3. frame_start has identical latency from vsync_in.
- line_start and column_count == 0 always coincide. Real line period = accepted period + 1 cycles, synthetic = H_MAX + 1.
- locked rises on the cycle after the LOCK_LINES-th good line_start and falls on the cycle after the loss condition.
- active is registered: it reflects the counts of the same cycle, with the window compare done on next-state values.

## Configuration
- SYNC_FLYWHEEL_EN defined: synthetic lines as above.
- Undefined:
  - No synthetic lines; column_count saturates at 1023.
  - column_count reaching H_MAX in VERIFY or LOCKED forces SEARCH immediately.
  - MISS_LIMIT is unused.

## Test plan
- Reset, then 20 lines of csync period 254 with vs_fall at start → locked rises after line 8; line_count 0..20; line_start every 255 clk.
- Locked, then inject a csync pulse at column 127 (half-line) → ignored; line_count and column_count unaffected; locked stays 1.
- Locked, then remove csync for 3 lines (flywheel build) → synthetic line_start at column 260; locked stays 1. Remove for 4 lines → locked drops after 4th synthetic line.
- vs_fall coincident with hsync → line_count = 0, column_count = 0, frame_start and line_start both high in the same cycle.
- In VERIFY, one line period 230 → SEARCH, locked stays 0. Assert reset mid-line in LOCKED → all outputs 0 the same cycle.
- Build without SYNC_FLYWHEEL_EN, locked, one missing csync → SEARCH at column 260; column_count saturates at 1023.
